// File: rtl/dmd_frame_timing_gen_if.sv
// Frame timing bundle between the timing generator (master) and the
// WPS pixel sender (slave). Trigger and offset flow toward the master.
// Timing, status and the latched offset flow back to the slave.
interface dmd_frame_timing_gen_if;
  logic        frame_trig;
  logic [23:0] left_offset_in;
  logic        frame_busy;
  logic        h_sync;
  logic        v_sync;
  logic        de;
  logic        de_first_offset_line;
  logic [23:0] display_video_left_offset;
  logic        frame_done;
  logic [15:0] frame_count;

  modport master (
    input  frame_trig,
    input  left_offset_in,
    output frame_busy,
    output h_sync,
    output v_sync,
    output de,
    output de_first_offset_line,
    output display_video_left_offset,
    output frame_done,
    output frame_count
  );

  modport slave (
    output frame_trig,
    output left_offset_in,
    input  frame_busy,
    input  h_sync,
    input  v_sync,
    input  de,
    input  de_first_offset_line,
    input  display_video_left_offset,
    input  frame_done,
    input  frame_count
  );
endinterface

// File: rtl/dmd_frame_timing_gen.sv
// Single-shot DMD frame timing generator. Each trigger accepted in IDLE
// produces exactly one frame of h_sync / v_sync / de. The leading
// OFFSET_LINES active lines are flagged, and the left-offset pixel
// value is latched for the sender. Every output comes straight from a flop.
module dmd_frame_timing_gen #(
  parameter int H_SYNC       = 4,
  parameter int H_BP         = 8,
  parameter int H_ACTIVE     = 82,
  parameter int H_FP         = 6,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 3,
  parameter int V_ACTIVE     = 1081,
  parameter int V_FP         = 4,
  parameter int OFFSET_LINES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmd_frame_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Geometry limits: 12-bit counters, and each sync/porch must be non-empty
  // so that every frame starts with a sync edge and ends with de low.
  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("dmd_frame_timing_gen: H_TOTAL or V_TOTAL exceeds 4095");
  end
  if (H_SYNC < 1 || H_FP < 1 || V_SYNC < 1 || V_FP < 1) begin : g_bad_min
    $error("dmd_frame_timing_gen: H_SYNC, H_FP, V_SYNC and V_FP must be >= 1");
  end
  if (OFFSET_LINES < 0 || OFFSET_LINES > V_ACTIVE) begin : g_bad_offset
    $error("dmd_frame_timing_gen: OFFSET_LINES must lie in 0..V_ACTIVE");
  end

  // Counter end points and decode windows, all sized to the counters.
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] H_DE_START  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_DE_END    = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] V_OFF_END   = 12'(V_SYNC + V_BP + OFFSET_LINES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic [23:0] offset_q, offset_d;
  logic [15:0] count_q, count_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        h_sync_q, h_sync_d;
  logic        v_sync_q, v_sync_d;
  logic        de_q, de_d;
  logic        de_off_q, de_off_d;
  logic        line_active_d;
  logic        h_active_d;

  // Next state, counter stepping, trigger acceptance and frame-end bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    offset_d = offset_q;
    count_d  = count_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vid.frame_trig) begin
          state_d  = ST_RUN;
          h_cnt_d  = '0;
          v_cnt_d  = '0;
          offset_d = vid.left_offset_in;
        end
      end
      ST_RUN: begin
        // Triggers are deliberately ignored here: no queuing of frames.
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            state_d = ST_IDLE;
            v_cnt_d = '0;
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
          end else begin
            v_cnt_d = v_cnt_q + 12'd1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next-cycle position, so the registered outputs
  // line up with the counters they describe.
  always_comb begin
    busy_d        = (state_d == ST_RUN);
    line_active_d = (v_cnt_d >= V_ACT_START) && (v_cnt_d < V_ACT_END);
    h_active_d    = (h_cnt_d >= H_DE_START) && (h_cnt_d < H_DE_END);
    h_sync_d      = busy_d && (h_cnt_d < H_SYNC_END);
    v_sync_d      = busy_d && (v_cnt_d < V_SYNC_END);
    de_d          = busy_d && line_active_d && h_active_d;
    de_off_d      = de_d && (v_cnt_d < V_OFF_END);
  end

  // State, counters and registered outputs; synchronous reset aborts a frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      offset_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      h_sync_q <= 1'b0;
      v_sync_q <= 1'b0;
      de_q     <= 1'b0;
      de_off_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      offset_q <= offset_d;
      count_q  <= count_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      h_sync_q <= h_sync_d;
      v_sync_q <= v_sync_d;
      de_q     <= de_d;
      de_off_q <= de_off_d;
    end
  end

  assign vid.frame_busy                = busy_q;
  assign vid.h_sync                    = h_sync_q;
  assign vid.v_sync                    = v_sync_q;
  assign vid.de                        = de_q;
  assign vid.de_first_offset_line      = de_off_q;
  assign vid.display_video_left_offset = offset_q;
  assign vid.frame_done                = done_q;
  assign vid.frame_count               = count_q;

endmodule

// File: tb/tb_dmd_frame_timing_gen.sv
// Bench for dmd_frame_timing_gen. A small-geometry instance is driven
// through directed steps, and a medium-geometry instance checks
// multi-line offsets. Expected frames are queued at trigger time and
// compared against per-frame statistics when frame_done is seen.
module tb_dmd_frame_timing_gen;

  // Small geometry: H 2/3/4/1 (10), V 1/1/3/1 (6) -> 60 cycles per frame.
  localparam int S_HS = 2, S_HBP = 3, S_HA = 4, S_HFP = 1;
  localparam int S_VS = 1, S_VBP = 1, S_VA = 3, S_VFP = 1, S_OFF = 1;
  localparam int S_HT = S_HS + S_HBP + S_HA + S_HFP;
  localparam int S_VT = S_VS + S_VBP + S_VA + S_VFP;
  // Medium geometry: H 3/5/20/2 (30), V 2/2/40/3 (47), three offset lines.
  localparam int M_HS = 3, M_HBP = 5, M_HA = 20, M_HFP = 2;
  localparam int M_VS = 2, M_VBP = 2, M_VA = 40, M_VFP = 3, M_OFF = 3;
  localparam int M_HT = M_HS + M_HBP + M_HA + M_HFP;
  localparam int M_VT = M_VS + M_VBP + M_VA + M_VFP;

  typedef struct {
    logic [23:0] offset;
    logic [15:0] count;
  } exp_t;

  typedef struct {
    int          busy;
    int          hs;
    int          vs;
    int          vs_rises;
    bit          vs_start;
    int          de_rises;
    int          de_len;
    int          de_bad;
    int          deo;
    int          deo_bad;
    logic [23:0] off_first;
    int          off_changes;
    bit          prev_busy;
    bit          prev_de;
    bit          prev_vs;
  } mon_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  exp_t q_s[$];
  exp_t q_m[$];
  mon_t mon_s, mon_m;
  int   idle_bad_s = 0;
  int   idle_bad_m = 0;

  always #5 clk = ~clk;

  dmd_frame_timing_gen_if s_if();
  dmd_frame_timing_gen_if m_if();

  dmd_frame_timing_gen #(
    .H_SYNC(S_HS), .H_BP(S_HBP), .H_ACTIVE(S_HA), .H_FP(S_HFP),
    .V_SYNC(S_VS), .V_BP(S_VBP), .V_ACTIVE(S_VA), .V_FP(S_VFP),
    .OFFSET_LINES(S_OFF)
  ) dut_s (
    .clk  (clk),
    .rst_n(rst_n),
    .vid  (s_if.master)
  );

  dmd_frame_timing_gen #(
    .H_SYNC(M_HS), .H_BP(M_HBP), .H_ACTIVE(M_HA), .H_FP(M_HFP),
    .V_SYNC(M_VS), .V_BP(M_VBP), .V_ACTIVE(M_VA), .V_FP(M_VFP),
    .OFFSET_LINES(M_OFF)
  ) dut_m (
    .clk  (clk),
    .rst_n(rst_n),
    .vid  (m_if.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accumulate one busy or idle cycle of outputs into the frame statistics.
  task automatic mon_sample(inout mon_t m, inout int idle_bad,
                            input logic busy, hs, vs, de, deo,
                            input logic [23:0] off, input int h_act, input int off_lines);
    if (busy) begin
      if (!m.prev_busy) begin
        m.off_first = off;
        m.vs_start  = vs;
      end else if (off !== m.off_first) begin
        m.off_changes++;
      end
      m.busy++;
      if (hs) m.hs++;
      if (vs) begin
        m.vs++;
        if (!m.prev_vs) m.vs_rises++;
      end
      if (de) begin
        if (!m.prev_de) begin
          m.de_rises++;
          m.de_len = 0;
        end
        m.de_len++;
      end else if (m.prev_de && m.de_len != h_act) begin
        m.de_bad++;
      end
      if (deo) begin
        m.deo++;
        if (!de || m.de_rises > off_lines) m.deo_bad++;
      end
    end else if (hs || vs || de || deo) begin
      idle_bad++;
    end
    m.prev_busy = busy;
    m.prev_de   = de;
    m.prev_vs   = vs;
  endtask

  // Compare one finished frame against the queued expectation and geometry.
  task automatic frame_check(input string tag, input mon_t m, input exp_t e,
                             input logic [23:0] off_now, input logic [15:0] cnt,
                             input int ht, vt, hsw, vsw, ha, va, offl);
    check({tag, ".busy_cycles"}, m.busy, ht * vt);
    check({tag, ".hsync_cycles"}, m.hs, hsw * vt);
    check({tag, ".vsync_cycles"}, m.vs, vsw * ht);
    check({tag, ".vsync_rises"}, m.vs_rises, 1);
    check({tag, ".vsync_at_start"}, 32'(m.vs_start), 1);
    check({tag, ".de_rises"}, m.de_rises, va);
    check({tag, ".de_bad_width"}, m.de_bad, 0);
    check({tag, ".offset_cycles"}, m.deo, offl * ha);
    check({tag, ".offset_misplaced"}, m.deo_bad, 0);
    check({tag, ".offset_value"}, 32'(m.off_first), 32'(e.offset));
    check({tag, ".offset_stable"}, m.off_changes, 0);
    check({tag, ".offset_held"}, 32'(off_now), 32'(e.offset));
    check({tag, ".frame_count"}, 32'(cnt), 32'(e.count));
  endtask

  // Small-instance scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_s = '{default: 0};
    end else if (s_if.frame_done) begin
      check("s.frame_expected", 32'(q_s.size() > 0), 1);
      if (q_s.size() > 0)
        frame_check("s", mon_s, q_s.pop_front(), s_if.display_video_left_offset,
                    s_if.frame_count, S_HT, S_VT, S_HS, S_VS, S_HA, S_VA, S_OFF);
      mon_s = '{default: 0};
    end else begin
      mon_sample(mon_s, idle_bad_s, s_if.frame_busy, s_if.h_sync, s_if.v_sync, s_if.de,
                 s_if.de_first_offset_line, s_if.display_video_left_offset, S_HA, S_OFF);
    end
  end

  // Medium-instance scoreboard monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_m = '{default: 0};
    end else if (m_if.frame_done) begin
      check("m.frame_expected", 32'(q_m.size() > 0), 1);
      if (q_m.size() > 0)
        frame_check("m", mon_m, q_m.pop_front(), m_if.display_video_left_offset,
                    m_if.frame_count, M_HT, M_VT, M_HS, M_VS, M_HA, M_VA, M_OFF);
      mon_m = '{default: 0};
    end else begin
      mon_sample(mon_m, idle_bad_m, m_if.frame_busy, m_if.h_sync, m_if.v_sync, m_if.de,
                 m_if.de_first_offset_line, m_if.display_video_left_offset, M_HA, M_OFF);
    end
  end

  // Wait (bounded) until frame_done is seen on the small instance.
  task automatic wait_done_s(input string tag, input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (s_if.frame_done) break;
      n++;
    end
    check({tag, ".done_in_time"}, 32'(n < budget), 1);
  endtask

  // One-cycle trigger on the small instance, driven just after a rising edge.
  task automatic trig_s(input logic [23:0] off);
    s_if.frame_trig     = 1'b1;
    s_if.left_offset_in = off;
    @(posedge clk); #1;
    s_if.frame_trig     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sb[0:63], shs[0:63], svs[0:63], sde[0:63], sdeo[0:63], sdone[0:63];
    logic [15:0] scnt[0:63];
    logic [15:0] exp_cnt = 16'd0;
    int          n_busy, n_de, n_deo, n;

    rst_n = 1'b0;
    s_if.frame_trig = 1'b0;
    s_if.left_offset_in = 24'h0;
    m_if.frame_trig = 1'b0;
    m_if.left_offset_in = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state.
    check("rst.busy", 32'(s_if.frame_busy), 0);
    check("rst.outputs", 32'({s_if.h_sync, s_if.v_sync, s_if.de,
                              s_if.de_first_offset_line, s_if.frame_done}), 0);
    check("rst.count", 32'(s_if.frame_count), 0);
    check("rst.offset", 32'(s_if.display_video_left_offset), 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end

    // Step 1: single frame, cycle-accurate snapshot around the trigger.
    s_if.frame_trig = 1'b1;
    s_if.left_offset_in = 24'h00C0DE;
    q_s.push_back('{24'h00C0DE, ++exp_cnt});
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      sb[i] = s_if.frame_busy;     shs[i] = s_if.h_sync;  svs[i] = s_if.v_sync;
      sde[i] = s_if.de;            sdeo[i] = s_if.de_first_offset_line;
      sdone[i] = s_if.frame_done;  scnt[i] = s_if.frame_count;
      if (i == 0) begin @(posedge clk); #1; s_if.frame_trig = 1'b0; end
    end
    check("s1.busy_before", 32'(sb[0]), 0);
    check("s1.busy_first", 32'(sb[1]), 1);
    check("s1.busy_last", 32'(sb[60]), 1);
    check("s1.busy_after", 32'(sb[61]), 0);
    check("s1.done_early", 32'(sdone[60]), 0);
    check("s1.done_pulse", 32'(sdone[61]), 1);
    check("s1.done_width", 32'(sdone[62]), 0);
    check("s1.hsync_h0", 32'(shs[1]), 1);
    check("s1.hsync_h1", 32'(shs[2]), 1);
    check("s1.hsync_h2", 32'(shs[3]), 0);
    check("s1.hsync_next_line", 32'(shs[11]), 1);
    check("s1.vsync_first", 32'(svs[1]), 1);
    check("s1.vsync_last", 32'(svs[10]), 1);
    check("s1.vsync_end", 32'(svs[11]), 0);
    check("s1.de_v2_h4", 32'(sde[25]), 0);
    check("s1.de_v2_h5", 32'(sde[26]), 1);
    check("s1.de_v2_h8", 32'(sde[29]), 1);
    check("s1.de_v2_h9", 32'(sde[30]), 0);
    check("s1.deo_v2_h5", 32'(sdeo[26]), 1);
    check("s1.de_v3_h5", 32'(sde[36]), 1);
    check("s1.deo_v3_h5", 32'(sdeo[36]), 0);
    check("s1.de_v4_h8", 32'(sde[49]), 1);
    check("s1.de_v5_h5", 32'(sde[56]), 0);
    check("s1.count_before", 32'(scnt[60]), 0);
    check("s1.count_after", 32'(scnt[61]), 1);
    n_busy = 0; n_de = 0; n_deo = 0;
    for (int i = 1; i <= 60; i++) begin
      n_busy += int'(sb[i]); n_de += int'(sde[i]); n_deo += int'(sdeo[i]);
    end
    check("s1.busy_total", n_busy, 60);
    check("s1.de_total", n_de, 12);
    check("s1.deo_total", n_deo, 4);

    // Step 2: trigger held high through most of a frame -> one frame only.
    @(posedge clk); #1;
    s_if.frame_trig = 1'b1;
    s_if.left_offset_in = 24'h000111;
    q_s.push_back('{24'h000111, ++exp_cnt});
    repeat (50) begin @(posedge clk); #1; end
    s_if.frame_trig = 1'b0;
    wait_done_s("s2", 200);
    n_busy = 0;
    repeat (5) begin @(negedge clk); n_busy += int'(s_if.frame_busy); end
    check("s2.no_second_frame", n_busy, 0);
    check("s2.count", 32'(s_if.frame_count), 32'(exp_cnt));

    // Step 3: trigger coincident with frame_done -> back-to-back frames.
    @(posedge clk); #1;
    q_s.push_back('{24'h00AAAA, ++exp_cnt});
    trig_s(24'h00AAAA);
    wait_done_s("s3a", 200);
    check("s3.gap_idle", 32'(s_if.frame_busy), 0);
    s_if.frame_trig = 1'b1;
    s_if.left_offset_in = 24'h00BBBB;
    q_s.push_back('{24'h00BBBB, ++exp_cnt});
    @(posedge clk); #1;
    s_if.frame_trig = 1'b0;
    @(negedge clk);
    check("s3.second_busy", 32'(s_if.frame_busy), 1);
    wait_done_s("s3b", 200);
    check("s3.count", 32'(s_if.frame_count), 32'(exp_cnt));

    // Step 4: offset latched at trigger, held through input changes.
    @(posedge clk); #1;
    q_s.push_back('{24'hA5A5A5, ++exp_cnt});
    trig_s(24'hA5A5A5);
    repeat (20) begin @(posedge clk); #1; end
    s_if.left_offset_in = 24'h123456;
    wait_done_s("s4a", 200);
    repeat (3) @(negedge clk);
    check("s4.offset_held_idle", 32'(s_if.display_video_left_offset), 32'h00A5A5A5);
    @(posedge clk); #1;
    q_s.push_back('{24'h123456, ++exp_cnt});
    trig_s(24'h123456);
    @(negedge clk);
    check("s4.offset_new", 32'(s_if.display_video_left_offset), 32'h00123456);
    wait_done_s("s4b", 200);

    // Step 5: one-cycle reset in the middle of an active line.
    @(posedge clk); #1;
    trig_s(24'h00DEAD);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (s_if.de) break;
      n++;
    end
    check("s5.de_seen", 32'(n < 100), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("s5.busy", 32'(s_if.frame_busy), 0);
    check("s5.outputs", 32'({s_if.h_sync, s_if.v_sync, s_if.de,
                             s_if.de_first_offset_line, s_if.frame_done}), 0);
    check("s5.offset", 32'(s_if.display_video_left_offset), 0);
    check("s5.count", 32'(s_if.frame_count), 0);
    exp_cnt = 16'd0;
    @(posedge clk); #1;
    q_s.push_back('{24'h00FACE, ++exp_cnt});
    trig_s(24'h00FACE);
    wait_done_s("s5", 200);

    // Step 6: medium geometry with several offset lines.
    @(posedge clk); #1;
    q_m.push_back('{24'h5A5A5A, 16'd1});
    m_if.frame_trig = 1'b1;
    m_if.left_offset_in = 24'h5A5A5A;
    @(posedge clk); #1;
    m_if.frame_trig = 1'b0;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (m_if.frame_done) break;
      n++;
    end
    check("m.done_in_time", 32'(n < 3000), 1);

    repeat (4) @(negedge clk);
    check("s.queue_drained", q_s.size(), 0);
    check("m.queue_drained", q_m.size(), 0);
    check("s.idle_outputs_low", idle_bad_s, 0);
    check("m.idle_outputs_low", idle_bad_m, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmd_frame_timing_gen.md
Name: dmd_frame_timing_gen

Overview:
- Single-shot video timing generator, sitting directly upstream of the WPS pixel sender.
- On each accepted frame_trig it produces exactly one frame of h_sync, v_sync and de.
- It flags the first OFFSET_LINES active lines as offset lines and supplies a latched left-offset pixel value.
- It holds frame_busy high for the whole frame, so the sender can pace frame-by-frame playback.

Parameters:
- H_SYNC, 4, h_sync width in clk cycles (>=1)
- H_BP, 8, cycles between h_sync end and de start
- H_ACTIVE, 82, de-high cycles per active line
- H_FP, 6, cycles after de end to line end (>=1)
- V_SYNC, 2, v_sync width in lines (>=1)
- V_BP, 3, lines between v_sync end and first active line
- V_ACTIVE, 1081, active lines, offset lines included
- V_FP, 4, lines after last active line (>=1)
- OFFSET_LINES, 1, leading active lines flagged as offset lines (0..V_ACTIVE)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_trig  in  1  single-cycle request to generate one frame
- left_offset_in  in  24  offset pixel value; sampled on accepted trig
- frame_busy  out  1  high while a frame is being generated
- h_sync  out  1  active-high line sync
- v_sync  out  1  active-high frame sync
- de  out  1  active-video enable
- de_first_offset_line  out  1  high with de during offset lines only
- display_video_left_offset  out  24  latched offset value
- frame_done  out  1  one-cycle pulse at frame end
- frame_count  out  16  frames completed since reset

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. While rst_n=0 all outputs are 0, counters are 0, state is IDLE. Reset mid-frame aborts immediately and outputs drop to 0 on the next edge.
- Derived values: H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP. V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP. Both must be <=4095; counters h_cnt and v_cnt are 12 bits.
- States: IDLE and RUN.
- IDLE behaviour: frame_busy, h_sync, v_sync, de and de_first_offset_line are all 0.
- Trig acceptance: frame_trig=1 in IDLE at edge T is accepted. At T+1 the block is in RUN with frame_busy=1, h_cnt=0 and v_cnt=0. display_video_left_offset takes left_offset_in sampled at T and holds it until the next accepted trig.
- frame_trig is ignored while in RUN; no queuing.
- All outputs are registered. In every RUN cycle the outputs reflect the current (h_cnt, v_cnt):
  - h_sync = h_cnt < H_SYNC
  - v_sync = v_cnt < V_SYNC (whole lines, aligned with h_cnt=0)
  - line active = V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE
  - de = line active AND H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE
  - de_first_offset_line = de AND v_cnt < V_SYNC+V_BP+OFFSET_LINES
- Counter stepping: h_cnt wraps at H_TOTAL-1 and increments v_cnt.
- Frame end: at h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 the next edge returns to IDLE. frame_busy falls, frame_done pulses high for one cycle (the first IDLE cycle), and frame_count increments, wrapping 0xFFFF to 0.
- Back-to-back frames: a trig in the first IDLE cycle after a frame (coincident with frame_done) is accepted; the minimum inter-frame gap is 1 IDLE cycle.
- Frame length: exactly H_TOTAL*V_TOTAL busy cycles. Each frame has exactly V_ACTIVE de pulses, each exactly H_ACTIVE cycles long.
- Downstream contract: de rises exactly V_ACTIVE times per frame, so the sender's line counter reaches V_ACTIVE at the last de fall. v_sync rises only at the start of a frame.

Test Plan:
- Small geometry: H=2/3/4/1 (sync/bp/active/fp), V=1/1/3/1, OFFSET_LINES=1, trig at cycle 10 -> busy high for cycles 11..70 (60 cycles). de high for 4 cycles at h_cnt 5..8 on v_cnt 2,3,4. de_first_offset_line high only on v_cnt=2. v_sync high cycles 11..20. frame_done at cycle 71. frame_count=1.
- Trig pulses repeated every cycle during a frame -> exactly one frame generated; frame_count increments by 1 only.
- Trig coincident with frame_done -> second frame starts on the next cycle; two busy windows separated by one low cycle; frame_count=2.
- left_offset_in=0xA5A5A5 at trig, changed to 0x123456 mid-frame -> display_video_left_offset stays 0xA5A5A5 all frame; it becomes 0x123456 only after the next trig.
- rst_n=0 for one cycle mid-active-line -> next cycle all outputs 0 and IDLE; frame_count=0; a following trig produces a full clean frame.
- Default parameters, one trig -> 109000 busy cycles. 1081 de rises, each 82 cycles wide. de_first_offset_line on the first de line only. frame_count=1.
